parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
Serial parity-checking receiver. It sits directly downstream of the team's XOR parity gates and is their sequential consumer. It accepts a bit stream one bit per accepted cycle, assembles DATA_W data bits (LSB first) followed by one parity bit, and checks the running XOR against that parity bit. It presents each completed word with an error flag on a valid/ready output port.

Parameters:
DATA_W, 8, number of data bits per frame (2..32)
ODD, 0, parity sense: 0 = even parity (XOR of data and parity bits must be 0), 1 = odd parity (XOR must be 1)

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
bit_in  in  1  serial bit
bit_valid  in  1  bit_in is consumed this cycle; always accepted, no backpressure
sof  in  1  start-of-frame resync strobe
data_out  out  DATA_W  assembled data word, bit 0 = first received bit
par_err  out  1  parity mismatch for data_out
out_valid  out  1  data_out/par_err hold a frame
out_ready  in  1  downstream accepts the frame
overrun  out  1  one-cycle pulse: a completed frame was dropped

Behaviour:
- Reset (rst=1 at edge): data_out=0, par_err=0, out_valid=0, overrun=0, bit counter=0, accumulator=0, shift register=0, state=S_DATA. Reset mid-frame discards the partial frame. Reset also discards any held output frame.
- States:
  - S_DATA: counter 0..DATA_W-1.
  - S_PAR: expecting the parity bit.
- S_DATA with bit_valid:
  - shreg[cnt] <= bit_in.
  - acc <= acc ^ bit_in.
  - cnt++.
  - When cnt == DATA_W-1, move to S_PAR.
- S_PAR with bit_valid (frame complete):
  - err = acc ^ bit_in ^ ODD.
  - Set cnt=0, acc=0, go to S_DATA.
- Output slot free means out_valid==0 or out_ready==1 in the same cycle.
  - Slot free at frame completion: load data_out <= shreg, par_err <= err, out_valid <= 1.
  - Slot not free: frame dropped, overrun=1 for exactly the next cycle, held output unchanged.
- Latency: out_valid rises on the cycle after the parity bit is accepted.
- Gaps in bit_valid are allowed; state holds while bit_valid=0.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - out_valid, data_out and par_err stay stable until the transfer.
  - After a transfer with no new frame completing, out_valid <= 0.
  - Back-to-back: a new frame completing in the same cycle as the transfer loads the slot, so out_valid stays 1.
- sof:
  - sof=1 clears cnt and acc and forces S_DATA; the partial frame is discarded silently (no overrun).
  - sof && bit_valid: bit_in is taken as data bit 0 of the new frame (cnt becomes 1).
  - sof never affects the output slot.
- sof and parity bit in the same cycle (S_PAR): sof wins. The bit is data bit 0 and no frame completes.
- Unused shreg bits are cleared at frame start so stale bits never leak.

Decomposition:
- Package parity_pkg:
  - state enum {S_DATA, S_PAR}
  - EVEN=0 / ODD=1 constants
  - default DATA_W
  - counter width function clog2(DATA_W)
- One natural sub-module: parity_acc. It is a 1-bit running-XOR register with clear and enable, instantiated once and built on the team's xor gate.
- Output slot logic stays inline.

Test Plan:
- Even, clean frame: DATA_W=8, ODD=0; send bits 1,0,1,0,0,1,0,1 then parity 0 -> next cycle out_valid=1, data_out=0xA5, par_err=0.
- Parity error: same 0xA5 with parity bit 1 -> data_out=0xA5, par_err=1. Also cover bit_valid gaps of 3 cycles between bits, with identical result.
- Backpressure and overrun: out_ready=0; send 0xA5 (p=0) then 0x0F (p=0) -> data_out stays 0xA5, overrun pulses 1 cycle after 0x0F's parity bit. Then set out_ready=1 -> one transfer, out_valid=0 next cycle.
- Back-to-back: out_ready=1 held; frames 0x01 (p=1) and 0x80 (p=1) with no gaps -> two transfers, par_err=0 both, overrun never 1.
- sof resync: send 3 bits of garbage, then sof with bit 0 of 0x3C, then the rest of 0x3C and p=0 -> data_out=0x3C, par_err=0, overrun=0.
- Odd parity and reset: ODD=1, 0x01 with p=0 -> par_err=0. Assert rst after 4 bits of the next frame -> all outputs 0. A following full frame 0xFF (p=1) gives data_out=0xFF, par_err=0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity-checking frame receiver.
package parity_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_e;

    localparam bit          PARITY_EVEN    = 1'b0;
    localparam bit          PARITY_ODD     = 1'b1;
    localparam int unsigned DEFAULT_DATA_W = 8;

    // Width of a counter that indexes data bits 0..data_w-1.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/parity_acc.sv
// One-bit running-XOR register; clear restarts the sum, and an enabled bit in
// the clear cycle becomes the first term of the new sum.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (clr || en) begin
            q <= (clr ? 1'b0 : q) ^ (en & d);
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial receiver: assembles DATA_W data bits (LSB first) plus one parity bit
// and presents each word with a parity-error flag on a valid/ready port.
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter bit          ODD    = PARITY_EVEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] data_out,
    output logic              par_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    localparam int unsigned      CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e              state;
    state_e              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_nx;
    logic                acc_q;
    logic                acc_clr_c;
    logic                acc_en_c;
    logic                frame_done_c;
    logic                err_c;
    logic                slot_free_c;

    parity_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr_c),
        .en  (acc_en_c),
        .d   (bit_in),
        .q   (acc_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_DATA;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shreg <= shreg_nx;
        end
    end

    // Bit assembly; sof takes priority over everything, including a parity bit.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        shreg_nx     = shreg;
        acc_clr_c    = 1'b0;
        acc_en_c     = 1'b0;
        frame_done_c = 1'b0;

        if (sof) begin
            state_nx  = S_DATA;
            cnt_nx    = '0;
            shreg_nx  = '0;
            acc_clr_c = 1'b1;
            if (bit_valid) begin
                shreg_nx[0] = bit_in;
                cnt_nx      = CNT_W'(1);
                acc_en_c    = 1'b1;
            end
        end else if (bit_valid) begin
            case (state)
                S_DATA: begin
                    if (cnt == '0) begin
                        shreg_nx = '0;
                    end
                    shreg_nx[cnt] = bit_in;
                    acc_en_c      = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_nx   = '0;
                        state_nx = S_PAR;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                S_PAR: begin
                    frame_done_c = 1'b1;
                    acc_clr_c    = 1'b1;
                    cnt_nx       = '0;
                    state_nx     = S_DATA;
                end
                default: begin
                    state_nx = S_DATA;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign err_c       = acc_q ^ bit_in ^ ODD;
    assign slot_free_c = !out_valid || out_ready;

    // Single-entry output slot; a frame that finds it occupied is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            par_err   <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done_c) begin
                if (slot_free_c) begin
                    data_out  <= shreg;
                    par_err   <= err_c;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: even and odd instances share stimulus and are
// compared every cycle with a frame-level reference model.
module tb_parity_frame_rx;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       sof;
    logic       out_ready;

    logic [7:0] e_data;
    logic       e_err;
    logic       e_val;
    logic       e_ovr;
    logic [7:0] o_data;
    logic       o_err;
    logic       o_val;
    logic       o_ovr;

    logic       m_fbits[$];
    logic [7:0] m_data;
    logic       m_err_e;
    logic       m_err_o;
    logic       m_valid;
    logic       m_ovr;

    int         checks;
    int         errors;
    logic       ovr_seen;

    parity_frame_rx #(.DATA_W(8), .ODD(1'b0)) u_even (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sof       (sof),
        .data_out  (e_data),
        .par_err   (e_err),
        .out_valid (e_val),
        .out_ready (out_ready),
        .overrun   (e_ovr)
    );

    parity_frame_rx #(.DATA_W(8), .ODD(1'b1)) u_odd (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sof       (sof),
        .data_out  (o_data),
        .par_err   (o_err),
        .out_valid (o_val),
        .out_ready (out_ready),
        .overrun   (o_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: a frame is the list of bits since the last start.
    task automatic model_edge(input logic bv, input logic b, input logic s,
                              input logic rdy, input logic r);
        logic       done;
        logic       free;
        logic [7:0] d;
        logic       p;
        done = 1'b0;
        d    = '0;
        p    = 1'b0;
        if (r) begin
            m_fbits.delete();
            m_data  = '0;
            m_err_e = 1'b0;
            m_err_o = 1'b0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        m_ovr = 1'b0;
        if (s) begin
            m_fbits.delete();
            if (bv) m_fbits.push_back(b);
        end else if (bv) begin
            if (m_fbits.size() == 8) begin
                for (int i = 0; i < 8; i++) d[i] = m_fbits[i];
                p    = b;
                done = 1'b1;
                m_fbits.delete();
            end else begin
                m_fbits.push_back(b);
            end
        end
        free = !m_valid || rdy;
        if (done) begin
            if (free) begin
                m_data  = d;
                m_err_e = (^d) ^ p;
                m_err_o = ~((^d) ^ p);
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input logic bv, input logic b, input logic s,
                         input logic rdy, input logic r);
        bit_valid = bv;
        bit_in    = b;
        sof       = s;
        out_ready = rdy;
        rst       = r;
        @(posedge clk);
        model_edge(bv, b, s, rdy, r);
        #1;
        ovr_seen = ovr_seen | e_ovr | o_ovr;
        chk("even.out_valid", 32'(e_val),  32'(m_valid));
        chk("even.data_out",  32'(e_data), 32'(m_data));
        chk("even.par_err",   32'(e_err),  32'(m_err_e));
        chk("even.overrun",   32'(e_ovr),  32'(m_ovr));
        chk("odd.out_valid",  32'(o_val),  32'(m_valid));
        chk("odd.data_out",   32'(o_data), 32'(m_data));
        chk("odd.par_err",    32'(o_err),  32'(m_err_o));
        chk("odd.overrun",    32'(o_ovr),  32'(m_ovr));
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int gap,
                              input logic rdy);
        for (int i = 0; i < 8; i++) begin
            idle(gap, rdy);
            cycle(1'b1, d[i], 1'b0, rdy, 1'b0);
        end
        idle(gap, rdy);
        cycle(1'b1, p, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic [7:0] v;
        checks   = 0;
        errors   = 0;
        ovr_seen = 1'b0;
        m_data   = '0;
        m_err_e  = 1'b0;
        m_err_o  = 1'b0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset.out_valid", 32'(e_val), 32'h0);
        chk("reset.data_out",  32'(e_data), 32'h0);
        chk("reset.overrun",   32'(e_ovr), 32'h0);
        idle(1, 1'b0);

        // Even clean frame
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        chk("clean.out_valid", 32'(e_val), 32'h1);
        chk("clean.data_out",  32'(e_data), 32'hA5);
        chk("clean.par_err",   32'(e_err), 32'h0);
        idle(1, 1'b1);
        chk("clean.drained",   32'(e_val), 32'h0);

        // Parity error, without and with 3-cycle gaps
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        chk("perr.data_out", 32'(e_data), 32'hA5);
        chk("perr.par_err",  32'(e_err), 32'h1);
        idle(1, 1'b1);
        send_frame(8'hA5, 1'b1, 3, 1'b0);
        chk("gap.data_out", 32'(e_data), 32'hA5);
        chk("gap.par_err",  32'(e_err), 32'h1);
        idle(1, 1'b1);

        // Backpressure and overrun
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        send_frame(8'h0F, 1'b0, 0, 1'b0);
        chk("ovr.pulse",    32'(e_ovr), 32'h1);
        chk("ovr.held",     32'(e_data), 32'hA5);
        idle(1, 1'b0);
        chk("ovr.one_cyc",  32'(e_ovr), 32'h0);
        chk("ovr.valid",    32'(e_val), 32'h1);
        idle(1, 1'b1);
        chk("ovr.xfer_done", 32'(e_val), 32'h0);

        // Back-to-back with ready held
        ovr_seen = 1'b0;
        send_frame(8'h01, 1'b1, 0, 1'b1);
        chk("b2b.first",     32'(e_data), 32'h01);
        chk("b2b.first_err", 32'(e_err), 32'h0);
        send_frame(8'h80, 1'b1, 0, 1'b1);
        chk("b2b.second",     32'(e_data), 32'h80);
        chk("b2b.second_err", 32'(e_err), 32'h0);
        chk("b2b.no_ovr",     32'(ovr_seen), 32'h0);
        idle(1, 1'b1);

        // sof resync after garbage
        ovr_seen = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        v = 8'h3C;
        cycle(1'b1, v[0], 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) cycle(1'b1, v[i], 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sof.data_out", 32'(e_data), 32'h3C);
        chk("sof.par_err",  32'(e_err), 32'h0);
        chk("sof.no_ovr",   32'(ovr_seen), 32'h0);
        idle(1, 1'b1);

        // Odd parity, then reset mid-frame
        send_frame(8'h01, 1'b0, 0, 1'b0);
        chk("odd.data_out", 32'(o_data), 32'h01);
        chk("odd.par_err",  32'(o_err), 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst.odd_valid", 32'(o_val), 32'h0);
        chk("rst.odd_data",  32'(o_data), 32'h0);
        chk("rst.odd_err",   32'(o_err), 32'h0);
        chk("rst.even_valid", 32'(e_val), 32'h0);
        idle(1, 1'b0);
        send_frame(8'hFF, 1'b1, 0, 1'b0);
        chk("rst.after_data", 32'(o_data), 32'hFF);
        chk("rst.after_err",  32'(o_err), 32'h0);
        chk("rst.after_valid", 32'(o_val), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
